// File: rtl/temperature_abnormality_responder_if.sv
// -----------------------------------------------------------------------------
// temperature_abnormality_responder_if
// Bundles the detector flags, enable and operator acknowledge with the actuator
// drives and status returned by the responder.
//   master : drives enable, lowTempAbnormality, highTempAbnormality, alarmAck;
//            observes heaterOn, coolerOn, alarm, state[2:0], faultCount[7:0]
//   slave  : the responder side of the same signals
// -----------------------------------------------------------------------------
interface temperature_abnormality_responder_if;
   logic       enable;
   logic       lowTempAbnormality;
   logic       highTempAbnormality;
   logic       alarmAck;
   logic       heaterOn;
   logic       coolerOn;
   logic       alarm;
   logic [2:0] state;
   logic [7:0] faultCount;

   modport master (
      output enable, lowTempAbnormality, highTempAbnormality, alarmAck,
      input  heaterOn, coolerOn, alarm, state, faultCount
   );

   modport slave (
      input  enable, lowTempAbnormality, highTempAbnormality, alarmAck,
      output heaterOn, coolerOn, alarm, state, faultCount
   );
endinterface

// File: rtl/temperature_abnormality_responder.sv
// -----------------------------------------------------------------------------
// temperature_abnormality_responder
// Moore FSM that debounces the low/high temperature abnormality flags, drives
// heater/cooler with a cooldown hold, and latches an acknowledged fault on
// contradictory flags.
// Ports:
//   clk  : system clock (rising edge)
//   rst  : synchronous, active-high reset
//   bus  : slave modport of temperature_abnormality_responder_if
//          inputs  enable, lowTempAbnormality, highTempAbnormality, alarmAck
//          outputs heaterOn, coolerOn, alarm, state[2:0], faultCount[7:0]
// Optional feature: define TEMP_RESPONDER_WATCHDOG_EN to add a watchdog that
// forces FAULT when an actuator stays on for WATCHDOG_CYCLES with its flag held.
// -----------------------------------------------------------------------------
module temperature_abnormality_responder #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned COOLDOWN_CYCLES = 8
`ifdef TEMP_RESPONDER_WATCHDOG_EN
   , parameter int unsigned WATCHDOG_CYCLES = 64
`endif
) (
   input  logic                                clk,
   input  logic                                rst,
   temperature_abnormality_responder_if.slave  bus
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned FC_W  = 8;

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);
   localparam logic [FC_W-1:0]  FC_MAX    = '1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_HEAT_PEND = 3'd1,
      S_HEATING   = 3'd2,
      S_COOL_PEND = 3'd3,
      S_COOLING   = 3'd4,
      S_FAULT     = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [FC_W-1:0]  fault_cnt_q, fault_cnt_d;
   logic             heater_q, cooler_q, alarm_q;

   logic low, high, both;

`ifdef TEMP_RESPONDER_WATCHDOG_EN
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WATCHDOG_CYCLES - 1);
   logic [CNT_W-1:0] wd_q, wd_d;
`endif

   assign low  = bus.lowTempAbnormality;
   assign high = bus.highTempAbnormality;
   assign both = low & high;

   // Next-state, counter and fault-count computation
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      fault_cnt_d = fault_cnt_q;
`ifdef TEMP_RESPONDER_WATCHDOG_EN
      wd_d        = wd_q;
`endif

      if (state_q != S_FAULT && both) begin
         state_d = S_FAULT;
         cnt_d   = '0;
         if (fault_cnt_q != FC_MAX) fault_cnt_d = fault_cnt_q + FC_W'(1);
      end else if (state_q != S_FAULT && !bus.enable) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               cnt_d = '0;
               if (low) begin
                  state_d = S_HEAT_PEND;
                  cnt_d   = CNT_W'(1);
               end else if (high) begin
                  state_d = S_COOL_PEND;
                  cnt_d   = CNT_W'(1);
               end
            end

            S_HEAT_PEND: begin
               if (!low) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == DEB_LAST) begin
                  state_d = S_HEATING;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end

            S_COOL_PEND: begin
               if (!high) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == DEB_LAST) begin
                  state_d = S_COOLING;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end

            S_HEATING: begin
               if (low) begin
                  cnt_d = '0;
`ifdef TEMP_RESPONDER_WATCHDOG_EN
                  if (wd_q == WD_LAST) begin
                     state_d = S_FAULT;
                     if (fault_cnt_q != FC_MAX) fault_cnt_d = fault_cnt_q + FC_W'(1);
                  end else begin
                     wd_d = wd_q + CNT_W'(1);
                  end
`endif
               end else if (high) begin
                  // Opposite flag takes over directly; heater drops this edge
                  state_d = S_COOL_PEND;
                  cnt_d   = CNT_W'(1);
               end else if (cnt_q == COOL_LAST) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end

            S_COOLING: begin
               if (high) begin
                  cnt_d = '0;
`ifdef TEMP_RESPONDER_WATCHDOG_EN
                  if (wd_q == WD_LAST) begin
                     state_d = S_FAULT;
                     if (fault_cnt_q != FC_MAX) fault_cnt_d = fault_cnt_q + FC_W'(1);
                  end else begin
                     wd_d = wd_q + CNT_W'(1);
                  end
`endif
               end else if (low) begin
                  state_d = S_HEAT_PEND;
                  cnt_d   = CNT_W'(1);
               end else if (cnt_q == COOL_LAST) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end

            S_FAULT: begin
               cnt_d = '0;
               // Acknowledge only counts with both flags clear; it is not held over
               if (bus.alarmAck && !low && !high) state_d = S_IDLE;
            end

            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end

`ifdef TEMP_RESPONDER_WATCHDOG_EN
      // Watchdog only accumulates while the active flag stays high in place
      if (state_d != state_q) wd_d = '0;
      if (!((state_q == S_HEATING && low) || (state_q == S_COOLING && high))) wd_d = '0;
`endif
   end

   // State, counters and outputs; outputs are decoded from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         fault_cnt_q <= '0;
         heater_q    <= 1'b0;
         cooler_q    <= 1'b0;
         alarm_q     <= 1'b0;
`ifdef TEMP_RESPONDER_WATCHDOG_EN
         wd_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         fault_cnt_q <= fault_cnt_d;
         heater_q    <= (state_d == S_HEATING);
         cooler_q    <= (state_d == S_COOLING);
         alarm_q     <= (state_d == S_FAULT);
`ifdef TEMP_RESPONDER_WATCHDOG_EN
         wd_q        <= wd_d;
`endif
      end
   end

   assign bus.heaterOn   = heater_q;
   assign bus.coolerOn   = cooler_q;
   assign bus.alarm      = alarm_q;
   assign bus.state      = 3'(state_q);
   assign bus.faultCount = fault_cnt_q;

endmodule

// File: tb/tb_temperature_abnormality_responder.sv
// -----------------------------------------------------------------------------
// tb_temperature_abnormality_responder
// Directed-vector bench for temperature_abnormality_responder with default
// parameters (DEBOUNCE=4, COOLDOWN=8, WATCHDOG=64).
// -----------------------------------------------------------------------------
module tb_temperature_abnormality_responder;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;
   int   exp_fc;

   temperature_abnormality_responder_if bus_if ();

   temperature_abnormality_responder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock edge, then sample 1 ns later; heater/cooler exclusivity every cycle
   task automatic step();
      @(posedge clk);
      #1;
      check_eq("excl", 32'(bus_if.heaterOn & bus_if.coolerOn), 32'd0);
   endtask

   task automatic expect_out(input string tag, input logic [2:0] st,
                             input logic h, input logic c, input logic a);
      check_eq({tag, ".state"},  32'(bus_if.state),    32'(st));
      check_eq({tag, ".heater"}, 32'(bus_if.heaterOn), 32'(h));
      check_eq({tag, ".cooler"}, 32'(bus_if.coolerOn), 32'(c));
      check_eq({tag, ".alarm"},  32'(bus_if.alarm),    32'(a));
   endtask

   task automatic set_in(input logic en, input logic lo, input logic hi, input logic ack);
      bus_if.enable              = en;
      bus_if.lowTempAbnormality  = lo;
      bus_if.highTempAbnormality = hi;
      bus_if.alarmAck            = ack;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;

      // Reset
      rst = 1'b1;
      set_in(1, 0, 0, 0);
      step(); step();
      expect_out("reset", 3'd0, 0, 0, 0);
      check_eq("reset.fc", 32'(bus_if.faultCount), 32'd0);

      // Debounce of low flag: 0 -> 1,1,1,2
      rst = 1'b0;
      set_in(1, 1, 0, 0);
      step(); expect_out("deb1", 3'd1, 0, 0, 0);
      step(); expect_out("deb2", 3'd1, 0, 0, 0);
      step(); expect_out("deb3", 3'd1, 0, 0, 0);
      step(); expect_out("deb4", 3'd2, 1, 0, 0);

      // Cooldown with a low glitch at sample 5 restarting the count
      set_in(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(); expect_out("cool_a", 3'd2, 1, 0, 0);
      end
      set_in(1, 1, 0, 0);
      step(); expect_out("glitch", 3'd2, 1, 0, 0);
      set_in(1, 0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         step(); expect_out("cool_b", 3'd2, 1, 0, 0);
      end
      step(); expect_out("cool_end", 3'd0, 0, 0, 0);

      // Aborted debounce, then high debounce to COOLING
      set_in(1, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(); expect_out("abort", 3'd1, 0, 0, 0);
      end
      set_in(1, 0, 0, 0);
      step(); expect_out("abort_idle", 3'd0, 0, 0, 0);
      set_in(1, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         step(); expect_out("cdeb", 3'd3, 0, 0, 0);
      end
      step(); expect_out("cooling", 3'd4, 0, 1, 0);

      // Opposite flag in COOLING: cooler off at once, HEAT_PEND
      set_in(1, 1, 0, 0);
      step(); expect_out("cool2heat", 3'd1, 0, 0, 0);
      set_in(1, 0, 0, 0);
      step(); expect_out("c2h_idle", 3'd0, 0, 0, 0);

      // Contradictory flags in HEATING -> FAULT
      set_in(1, 1, 0, 0);
      repeat (4) step();
      expect_out("heat2", 3'd2, 1, 0, 0);
      set_in(1, 1, 1, 0);
      step(); expect_out("fault", 3'd5, 0, 0, 1);
      check_eq("fault.fc", 32'(bus_if.faultCount), 32'd1);
      set_in(1, 0, 1, 1);
      step(); expect_out("ack_ignored", 3'd5, 0, 0, 1);
      set_in(1, 0, 0, 1);
      step(); expect_out("ack", 3'd0, 0, 0, 0);

      // FAULT ignores enable
      set_in(1, 1, 1, 0);
      step(); expect_out("fault2", 3'd5, 0, 0, 1);
      check_eq("fault2.fc", 32'(bus_if.faultCount), 32'd2);
      set_in(0, 0, 0, 0);
      step(); expect_out("fault_en", 3'd5, 0, 0, 1);
      set_in(1, 0, 0, 1);
      step(); expect_out("ack2", 3'd0, 0, 0, 0);

      // enable=0 mid-debounce, then full debounce again, then enable=0 in HEATING
      set_in(1, 1, 0, 0);
      step(); step(); expect_out("mid", 3'd1, 0, 0, 0);
      set_in(0, 1, 0, 0);
      step(); expect_out("en_off", 3'd0, 0, 0, 0);
      set_in(1, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(); expect_out("rdeb", 3'd1, 0, 0, 0);
      end
      step(); expect_out("rheat", 3'd2, 1, 0, 0);
      set_in(0, 1, 0, 0);
      step(); expect_out("en_heat", 3'd0, 0, 0, 0);

      // faultCount saturation over 256 more entries
      exp_fc = 2;
      for (int i = 0; i < 256; i++) begin
         set_in(1, 1, 1, 0);
         step();
         exp_fc = (exp_fc == 255) ? 255 : exp_fc + 1;
         check_eq("sat.fc", 32'(bus_if.faultCount), 32'(exp_fc));
         set_in(1, 0, 0, 1);
         step();
      end
      check_eq("sat.final", 32'(bus_if.faultCount), 32'd255);

      // Reset has priority in FAULT
      set_in(1, 1, 1, 0);
      step(); expect_out("fault3", 3'd5, 0, 0, 1);
      rst = 1'b1;
      step(); expect_out("rst_fault", 3'd0, 0, 0, 0);
      check_eq("rst_fault.fc", 32'(bus_if.faultCount), 32'd0);
      rst = 1'b0;
      set_in(1, 0, 0, 0);
      step();

      // Continuous low in HEATING: watchdog behaviour
      set_in(1, 1, 0, 0);
      repeat (4) step();
      expect_out("wd_enter", 3'd2, 1, 0, 0);
      for (int i = 0; i < 63; i++) begin
         step(); expect_out("wd_hold", 3'd2, 1, 0, 0);
      end
      step();
`ifdef TEMP_RESPONDER_WATCHDOG_EN
      expect_out("wd_trip", 3'd5, 0, 0, 1);
      check_eq("wd_trip.fc", 32'(bus_if.faultCount), 32'd1);
`else
      expect_out("wd_none", 3'd2, 1, 0, 0);
      check_eq("wd_none.fc", 32'(bus_if.faultCount), 32'd0);
`endif
      set_in(1, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
